// File: rtl/seq_chan_mux_pkg.sv
// seq_chan_mux shared types: FSM state and mode encodings.
// Optional drop-on-timeout feature: SEQ_CHAN_MUX_TIMEOUT_EN.
package seq_chan_mux_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/seq_chan_mux_ptr.sv
// seq_chan_mux scan pointer: wrapping channel index.
// Advances by one per adv pulse, N-1 wraps to 0.
module seq_chan_mux_ptr #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          adv,
  output logic [SW-1:0] ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (adv) begin
      if (ptr == SW'(N - 1))
        ptr <= '0;
      else
        ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/seq_chan_mux.sv
// seq_chan_mux: manual/round-robin channel selector with registered output.
// Define SEQ_CHAN_MUX_TIMEOUT_EN to drop words held longer than TIMEOUT.
module seq_chan_mux
  import seq_chan_mux_pkg::*;
#(
  parameter int W       = 8,
  parameter int N       = 4,
  parameter int TIMEOUT = 16,
  localparam int SW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_ch,
  output logic           out_valid,
  input  logic           out_ready
`ifdef SEQ_CHAN_MUX_TIMEOUT_EN
  ,
  output logic           out_drop
`endif
);

  state_t        state, nxt;
  logic [SW-1:0] ptr;
  logic [SW-1:0] idx;
  logic [W-1:0]  word;
  logic          hit;
  logic          cap;
  logic          adv;
  logic          mode_q;

  assign idx       = (mode == MODE_SCAN) ? ptr : sel;
  assign out_valid = (state == PRESENT);

  // An out-of-range manual sel matches no channel, so hit stays 0.
  always_comb begin
    word = '0;
    hit  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (idx == SW'(k)) begin
        word = in_data[k*W +: W];
        hit  = in_valid[k];
      end
    end
  end

  seq_chan_mux_ptr #(
    .N  (N),
    .SW (SW)
  ) u_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (adv),
    .ptr   (ptr)
  );

`ifdef SEQ_CHAN_MUX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic          expire;

  assign expire = !out_ready && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      out_drop <= 1'b0;
    end else begin
      out_drop <= (state == PRESENT) && expire;
      if (cap)
        cnt <= '0;
      else if (state == PRESENT && !out_ready)
        cnt <= cnt + 1'b1;
    end
  end
`else
  logic expire;
  assign expire = 1'b0;
`endif

  always_comb begin
    nxt = state;
    cap = 1'b0;
    adv = 1'b0;
    unique case (state)
      IDLE: begin
        if (hit) begin
          nxt = PRESENT;
          cap = 1'b1;
        end else if (mode == MODE_SCAN) begin
          adv = 1'b1;
        end
      end
      PRESENT: begin
        // Transfer wins over an expiry landing on the same edge.
        if (out_ready || expire) begin
          nxt = IDLE;
          adv = (mode_q == MODE_SCAN);
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      out_data <= '0;
      out_ch   <= '0;
      mode_q   <= MODE_MANUAL;
    end else begin
      state <= nxt;
      if (cap) begin
        out_data <= word;
        out_ch   <= idx;
        mode_q   <= mode;
      end
    end
  end

endmodule

// File: tb/tb_seq_chan_mux.sv
// Directed bench for seq_chan_mux (N=4 main instance, N=3 for sel range).
// Timeout checks are active when SEQ_CHAN_MUX_TIMEOUT_EN is defined.
module tb_seq_chan_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] d0;
  logic [3:0]  v0;
  logic        m0;
  logic [1:0]  s0;
  logic [7:0]  od0;
  logic [1:0]  oc0;
  logic        ov0;
  logic        rdy0;
  logic [23:0] d1;
  logic [2:0]  v1;
  logic        m1;
  logic [1:0]  s1;
  logic [7:0]  od1;
  logic [1:0]  oc1;
  logic        ov1;
  logic        rdy1;
`ifdef SEQ_CHAN_MUX_TIMEOUT_EN
  logic        drp0;
  logic        drp1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_chan_mux #(.W(8), .N(4), .TIMEOUT(16)) u0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (d0),
    .in_valid  (v0),
    .mode      (m0),
    .sel       (s0),
    .out_data  (od0),
    .out_ch    (oc0),
    .out_valid (ov0),
    .out_ready (rdy0)
`ifdef SEQ_CHAN_MUX_TIMEOUT_EN
    ,
    .out_drop  (drp0)
`endif
  );

  seq_chan_mux #(.W(8), .N(3), .TIMEOUT(16)) u1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (d1),
    .in_valid  (v1),
    .mode      (m1),
    .sel       (s1),
    .out_data  (od1),
    .out_ch    (oc1),
    .out_valid (ov1),
    .out_ready (rdy1)
`ifdef SEQ_CHAN_MUX_TIMEOUT_EN
    ,
    .out_drop  (drp1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic out0(input string tag, input logic v,
                      input logic [7:0] d, input logic [1:0] c);
    chk({tag, ".v"}, 32'(ov0), 32'(v));
    chk({tag, ".d"}, 32'(od0), 32'(d));
    chk({tag, ".c"}, 32'(oc0), 32'(c));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    d0 = '0; v0 = '0; m0 = 1'b0; s0 = '0; rdy0 = 1'b0;
    d1 = '0; v1 = '0; m1 = 1'b0; s1 = '0; rdy1 = 1'b0;
    #3;
    out0("rst", 1'b0, 8'h00, 2'd0);
    chk("rst.v1", 32'(ov1), 32'd0);
    cyc(2);
    rst_n = 1'b1;

    // manual capture of channel 2
    m0 = 1'b0; s0 = 2'd2; v0 = 4'b0100;
    d0 = 32'h00A5_0000; rdy0 = 1'b1;
    cyc(1);
    out0("man", 1'b1, 8'hA5, 2'd2);
    v0 = '0;
    cyc(1);
    out0("man.done", 1'b0, 8'hA5, 2'd2);

    // round-robin: ch1 then ch3, then wrap to ch0
    m0 = 1'b1; v0 = 4'b1010; d0 = 32'h3300_1100;
    cyc(1);
    chk("scan.e1", 32'(ov0), 32'd0);
    cyc(1);
    out0("scan.c1", 1'b1, 8'h11, 2'd1);
    cyc(1);
    chk("scan.e3", 32'(ov0), 32'd0);
    cyc(1);
    chk("scan.e4", 32'(ov0), 32'd0);
    cyc(1);
    out0("scan.c3", 1'b1, 8'h33, 2'd3);
    v0 = 4'b0001; d0 = 32'h0000_0044;
    cyc(1);
    chk("scan.e6", 32'(ov0), 32'd0);
    cyc(1);
    out0("scan.wrap", 1'b1, 8'h44, 2'd0);
    v0 = '0;
    cyc(1);
    chk("scan.e8", 32'(ov0), 32'd0);

    // backpressure: held word survives input churn
    m0 = 1'b0; s0 = 2'd1; v0 = 4'b0010; d0 = 32'h0000_5A00;
    rdy0 = 1'b0;
    cyc(1);
    for (int i = 0; i < 5; i++) begin
      out0($sformatf("bp%0d", i), 1'b1, 8'h5A, 2'd1);
      d0 = $urandom; v0 = 4'($urandom);
      m0 = ~m0; s0 = 2'(i);
      cyc(1);
    end
    out0("bp5", 1'b1, 8'h5A, 2'd1);
    rdy0 = 1'b1; v0 = '0; m0 = 1'b0;
    cyc(1);
    out0("bp.xfer", 1'b0, 8'h5A, 2'd1);

    // N=3: sel=3 never captures, sel=2 does
    m1 = 1'b0; s1 = 2'd3; v1 = 3'b111; d1 = 24'h332211;
    rdy1 = 1'b1;
    cyc(4);
    chk("n3.sel3", 32'(ov1), 32'd0);
    s1 = 2'd2;
    cyc(1);
    chk("n3.sel2.v", 32'(ov1), 32'd1);
    chk("n3.sel2.d", 32'(od1), 32'h33);
    v1 = '0;

    // asynchronous reset while presenting
    s0 = 2'd0; v0 = 4'b0001; d0 = 32'h0000_0077; rdy0 = 1'b0;
    cyc(1);
    out0("pre.rst", 1'b1, 8'h77, 2'd0);
    #2 rst_n = 1'b0;
    #1 out0("mid.rst", 1'b0, 8'h00, 2'd0);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    out0("post.rst", 1'b1, 8'h77, 2'd0);
    rdy0 = 1'b1; v0 = '0;
    cyc(1);
    chk("post.xfer", 32'(ov0), 32'd0);

`ifdef SEQ_CHAN_MUX_TIMEOUT_EN
    // 16 stalled cycles then drop
    v0 = 4'b0001; rdy0 = 1'b0;
    cyc(1);
    v0 = '0;
    for (int i = 0; i < 16; i++) begin
      chk("to.hold", 32'(ov0), 32'd1);
      chk("to.nodrop", 32'(drp0), 32'd0);
      cyc(1);
    end
    chk("to.v", 32'(ov0), 32'd0);
    chk("to.drop", 32'(drp0), 32'd1);
    cyc(1);
    chk("to.drop1", 32'(drp0), 32'd0);
    // ready on the 16th cycle: transfer, no drop
    v0 = 4'b0001;
    cyc(1);
    v0 = '0;
    cyc(15);
    chk("to2.hold", 32'(ov0), 32'd1);
    rdy0 = 1'b1;
    cyc(1);
    chk("to2.v", 32'(ov0), 32'd0);
    chk("to2.drop", 32'(drp0), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
